// File: rtl/mult_sched_pkg.sv
// Shared types and default sizing for the multiplier-sharing scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

  localparam int WIDTH_DEF   = 8;
  localparam int TIMEOUT_DEF = 12;
  localparam int CNT_W       = $clog2(TIMEOUT_DEF);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_any
);

  always_comb begin
    grant_any = |valid;
    grant_id  = 1'b0;
    case (valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mult_share_scheduler.sv
// Shares one sequential shift-add multiplier between two requesters: arbitrate,
// load operand magnitudes, wait for the done flag, return a signed product.
module mult_share_scheduler
  import mult_sched_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [WIDTH-1:0]     req0_mp,
  input  logic [WIDTH-1:0]     req0_mc,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [WIDTH-1:0]     req1_mp,
  input  logic [WIDTH-1:0]     req1_mc,
  output logic                 req1_ready,
  output logic                 mult_load,
  output logic [WIDTH-1:0]     mult_mp,
  output logic [WIDTH-1:0]     mult_mc,
  input  logic                 mult_zero,
  input  logic [2*WIDTH-1:0]   mult_product,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [2*WIDTH-1:0]   resp_product,
  output logic                 resp_timeout,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              sign_q, sign_d;
  logic              id_q, id_d;
  logic [WIDTH-1:0]  mp_q, mp_d;
  logic [WIDTH-1:0]  mc_q, mc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     res_q, res_d;
  logic              to_q, to_d;

  logic              grant_id, grant_any, accept;
  logic [WIDTH-1:0]  sel_mp, sel_mc, mp_mag, mc_mag;

  rr_arbiter2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant_id   (grant_id),
    .grant_any  (grant_any)
  );

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign accept     = (state_q == IDLE) && !rst && grant_any;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  assign sel_mp = grant_id ? req1_mp : req0_mp;
  assign sel_mc = grant_id ? req1_mc : req0_mc;
  assign mp_mag = sel_mp[WIDTH-1] ? -sel_mp : sel_mp;
  assign mc_mag = sel_mc[WIDTH-1] ? -sel_mc : sel_mc;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sign_d       = sign_q;
    id_d         = id_q;
    mp_d         = mp_q;
    mc_d         = mc_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    to_d         = to_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mp_d    = mp_mag;
          mc_d    = mc_mag;
          sign_d  = sel_mp[WIDTH-1] ^ sel_mc[WIDTH-1];
          id_d    = grant_id;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (mult_zero) begin
          // A zero product stays positive even when the signs differ.
          res_d   = (sign_q && (mult_product != '0)) ? -mult_product : mult_product;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      sign_q       <= 1'b0;
      id_q         <= 1'b0;
      mp_q         <= '0;
      mc_q         <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sign_q       <= sign_d;
      id_q         <= id_d;
      mp_q         <= mp_d;
      mc_q         <= mc_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      to_q         <= to_d;
    end
  end

  assign mult_load    = (state_q == LOAD);
  assign mult_mp      = mp_q;
  assign mult_mc      = mc_q;
  assign resp_valid   = (state_q == RESP);
  assign resp_id      = id_q;
  assign resp_product = res_q;
  assign resp_timeout = to_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_scheduler.sv
// Directed bench for mult_share_scheduler with a behavioural shift-add datapath stand-in.
module tb_mult_share_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_mp = '0, req0_mc = '0, req1_mp = '0, req1_mc = '0;
  logic        req0_ready, req1_ready;
  logic        mult_load, mult_zero;
  logic [7:0]  mult_mp, mult_mc;
  logic [15:0] mult_product;
  logic        resp_valid, resp_id, resp_timeout, busy;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_product;

  int checks = 0;
  int passed = 0;
  int k_run = 4;
  bit zero_off = 1'b0;
  int rc;

  always #5 clk = ~clk;

  mult_share_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_mp(req0_mp), .req0_mc(req0_mc), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_mp(req1_mp), .req1_mc(req1_mc), .req1_ready(req1_ready),
    .mult_load(mult_load), .mult_mp(mult_mp), .mult_mc(mult_mc),
    .mult_zero(mult_zero), .mult_product(mult_product),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_product(resp_product), .resp_timeout(resp_timeout), .busy(busy)
  );

  // Datapath stand-in: reports done in its k_run-th cycle after the load strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) rc <= 0;
    else if (mult_load) rc <= 1;
    else if (rc < 1000) rc <= rc + 1;
  end
  assign mult_zero    = !zero_off && (rc == k_run);
  assign mult_product = 16'(mult_mp) * 16'(mult_mc);

  task automatic start_op(input bit id, input logic [7:0] mp, input logic [7:0] mc, output logic rdy);
    if (id) begin req1_valid = 1'b1; req1_mp = mp; req1_mc = mc; end
    else    begin req0_valid = 1'b1; req0_mp = mp; req0_mc = mc; end
    #1 rdy = id ? req1_ready : req0_ready;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Called at the negedge of cycle 1 (the LOAD cycle); returns the cycle of resp_valid or -1.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) lat = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req0_mp = 8'd3; req0_mc = 8'd4;
    #12;
    checks++;
    if ({req0_ready, req1_ready, mult_load, mult_mp, mult_mc, resp_valid, resp_id,
         resp_product, resp_timeout, busy} !== 39'h0)
      $display("FAIL reset_outputs: got ready0=%b load=%b mp=%h mc=%h rv=%b prod=%h busy=%b, want all 0",
               req0_ready, mult_load, mult_mp, mult_mc, resp_valid, resp_product, busy);
    else passed++;
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, resp_valid} !== 2'b00) $display("FAIL reset_release_idle: got busy=%b rv=%b want 0 0", busy, resp_valid);
    else passed++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic rdy; int lat;
    k_run = 4; resp_ready = 1'b0;
    @(negedge clk);
    start_op(1'b0, 8'd3, 8'hFB, rdy);
    checks++; if (rdy !== 1'b1) $display("FAIL single_ready: got %b want 1", rdy); else passed++;
    checks++; if ({mult_load, mult_mp, mult_mc} !== {1'b1, 8'd3, 8'd5})
      $display("FAIL single_load: got load=%b mp=%h mc=%h want 1 03 05", mult_load, mult_mp, mult_mc);
    else passed++;
    @(negedge clk);
    checks++; if ({mult_load, req0_ready} !== 2'b00)
      $display("FAIL single_load_pulse: got load=%b ready=%b in cycle 2 want 0 0", mult_load, req0_ready);
    else passed++;
    begin lat = 2; while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end if (!resp_valid) lat = -1; end
    checks++; if (lat !== 6) $display("FAIL single_latency: got %0d want 6", lat); else passed++;
    checks++; if ({resp_id, resp_product, resp_timeout, mult_mp, mult_mc} !== {1'b0, 16'hFFF1, 1'b0, 8'd3, 8'd5})
      $display("FAIL single_resp: got id=%b prod=%h to=%b mp=%h mc=%h want 0 fff1 0 03 05",
               resp_id, resp_product, resp_timeout, mult_mp, mult_mc);
    else passed++;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++; if ({resp_valid, busy} !== 2'b00) $display("FAIL single_handshake: got rv=%b busy=%b want 0 0", resp_valid, busy);
    else passed++;
    $display("test_single done: 3 * -5 -> %h", 16'hFFF1);
  endtask

  task automatic test_round_robin();
    int lat;
    do_reset();
    k_run = 3; resp_ready = 1'b1;
    req0_valid = 1'b1; req0_mp = 8'd2;   req0_mc = 8'd7;
    req1_valid = 1'b1; req1_mp = 8'hFC;  req1_mc = 8'd6;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL rr_first_tie: got r1r0=%b%b want 01", req1_ready, req0_ready); else passed++;
    @(negedge clk);
    req0_valid = 1'b0;
    wait_resp(lat);
    checks++; if ({lat == 5, resp_id, resp_product} !== {1'b1, 1'b0, 16'd14})
      $display("FAIL rr_resp0: got lat=%0d id=%b prod=%h want 5 0 000e", lat, resp_id, resp_product);
    else passed++;
    @(negedge clk);
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL rr_second: got r1r0=%b%b want 10", req1_ready, req0_ready); else passed++;
    @(negedge clk);
    req1_valid = 1'b0;
    wait_resp(lat);
    checks++; if ({lat == 5, resp_id, resp_product} !== {1'b1, 1'b1, 16'hFFE8})
      $display("FAIL rr_resp1: got lat=%0d id=%b prod=%h want 5 1 ffe8", lat, resp_id, resp_product);
    else passed++;
    @(negedge clk);
    req0_valid = 1'b1; req0_mp = 8'd5;  req0_mc = 8'd5;
    req1_valid = 1'b1; req1_mp = 8'hFD; req1_mc = 8'd3;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL rr_second_tie: got r1r0=%b%b want 01", req1_ready, req0_ready); else passed++;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(lat);
    checks++; if ({resp_id, resp_product} !== {1'b0, 16'd25})
      $display("FAIL rr_resp2: got id=%b prod=%h want 0 0019", resp_id, resp_product);
    else passed++;
    @(negedge clk);
    resp_ready = 1'b0;
    $display("test_round_robin done");
  endtask

  task automatic test_min_magnitude();
    logic rdy; int lat;
    k_run = 2; resp_ready = 1'b1;
    start_op(1'b0, 8'h80, 8'h80, rdy);
    checks++; if ({rdy, mult_mp, mult_mc} !== {1'b1, 8'h80, 8'h80})
      $display("FAIL minmag_load: got rdy=%b mp=%h mc=%h want 1 80 80", rdy, mult_mp, mult_mc);
    else passed++;
    wait_resp(lat);
    checks++; if (resp_product !== 16'h4000) $display("FAIL minmag_pos: got %h want 4000", resp_product); else passed++;
    @(negedge clk);
    start_op(1'b0, 8'h80, 8'h7F, rdy);
    wait_resp(lat);
    checks++; if ({mult_mc, resp_product} !== {8'h7F, 16'hC080})
      $display("FAIL minmag_neg: got mc=%h prod=%h want 7f c080", mult_mc, resp_product);
    else passed++;
    @(negedge clk);
    resp_ready = 1'b0;
    $display("test_min_magnitude done");
  endtask

  task automatic test_zero();
    logic rdy; int lat;
    k_run = 1; resp_ready = 1'b1;
    start_op(1'b0, 8'h00, 8'hFB, rdy);
    wait_resp(lat);
    checks++; if ({lat == 3, resp_product, resp_timeout, mult_mc} !== {1'b1, 16'h0000, 1'b0, 8'd5})
      $display("FAIL zero_result: got lat=%0d prod=%h to=%b mc=%h want 3 0000 0 05", lat, resp_product, resp_timeout, mult_mc);
    else passed++;
    @(negedge clk);
    resp_ready = 1'b0;
    $display("test_zero done");
  endtask

  task automatic test_timeout();
    logic rdy; int lat;
    zero_off = 1'b1; resp_ready = 1'b0;
    start_op(1'b0, 8'd2, 8'd3, rdy);
    wait_resp(lat);
    checks++; if ({lat == 14, resp_timeout, resp_product} !== {1'b1, 1'b1, 16'h0})
      $display("FAIL timeout_resp: got lat=%0d to=%b prod=%h want 14 1 0000", lat, resp_timeout, resp_product);
    else passed++;
    req1_valid = 1'b1; req1_mp = 8'd1; req1_mc = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_timeout, resp_id, resp_product, busy, req0_ready, req1_ready} !==
          {1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0})
        $display("FAIL timeout_hold%0d: got rv=%b to=%b id=%b prod=%h busy=%b r1=%b want 1 1 0 0000 1 0",
                 i, resp_valid, resp_timeout, resp_id, resp_product, busy, req1_ready);
      else passed++;
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b0) $display("FAIL timeout_hs_cycle_ready: got %b want 0", req1_ready); else passed++;
    @(negedge clk);
    #1;
    checks++; if ({resp_valid, req1_ready} !== 2'b01) $display("FAIL timeout_after_hs: got rv=%b r1=%b want 0 1", resp_valid, req1_ready); else passed++;
    req1_valid = 1'b0; resp_ready = 1'b0; zero_off = 1'b0;
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    k_run = 6; resp_ready = 1'b1;
    req1_valid = 1'b1; req1_mp = 8'hF9; req1_mc = 8'd9;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, mult_load, mult_mp, mult_mc, resp_valid, resp_id,
         resp_product, resp_timeout, busy} !== 39'h0)
      $display("FAIL midreset_outputs: got r1=%b mp=%h mc=%h busy=%b want all 0", req1_ready, mult_mp, mult_mc, busy);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    k_run = 2;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL midreset_reaccept: got r1r0=%b%b want 10", req1_ready, req0_ready); else passed++;
    @(negedge clk);
    req1_valid = 1'b0;
    checks++; if ({mult_load, mult_mp, mult_mc} !== {1'b1, 8'd7, 8'd9})
      $display("FAIL midreset_load: got load=%b mp=%h mc=%h want 1 07 09", mult_load, mult_mp, mult_mc);
    else passed++;
    wait_resp(lat);
    checks++; if ({lat == 4, resp_id, resp_product, resp_timeout} !== {1'b1, 1'b1, 16'hFFC1, 1'b0})
      $display("FAIL midreset_resp: got lat=%0d id=%b prod=%h to=%b want 4 1 ffc1 0", lat, resp_id, resp_product, resp_timeout);
    else passed++;
    @(negedge clk);
    resp_ready = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_min_magnitude();
    test_zero();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
